car_addr_arbiter: RTL
=====================

Name: car_addr_arbiter

Overview:
- Shares the 16-bit address bus among NREQ counter/address registers (PC, SP, SI, DI, ...).
- Grants one register at a time by driving that register's a_addr_n low for the memory access.
- After the access, issues the requested post-access adjust to the same register: an inc pulse (post-increment) or a dec pulse (stack pop/walk).
- Sits between the control/decode logic, which raises requests, and the counter/address register bank.

Parameters:
- NREQ, 4, number of counter/address registers (requesters); legal range 2..8.
- WAIT_CYCLES, 1, cycles a_addr_n is held low per access; legal range 1..15.
- GW, $clog2(NREQ), width of grant_id (derived; do not override).

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- clear_n  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester access request; level; sampled only in IDLE.
- req_op  input  2*NREQ  per-requester post-op, bits [2i+1:2i]: 00 none, 01 inc, 10 dec, 11 treated as none.
- ack  output  NREQ  one-cycle pulse to the granted requester in its last ADDR cycle.
- a_addr_n  output  NREQ  active-low address-bus enable, one bit per register; at most one bit low.
- inc  output  NREQ  post-increment strobe per register; the register acts on the rising edge.
- dec  output  NREQ  post-decrement strobe per register; the register acts on the rising edge.
- busy  output  1  high in every state except IDLE.
- grant_id  output  GW  index of the current or last granted requester.

Behaviour:
- All outputs are registered.
- Reset (clear_n low, asynchronous, effective mid-operation):
  - state=IDLE, a_addr_n=all 1, inc=0, dec=0, ack=0, busy=0, grant_id=0.
  - Round-robin pointer=NREQ-1, so requester 0 wins first.
- FSM states: IDLE, ADDR, POST, GAP.
- IDLE: if any req bit is high:
  - Pick the winner round-robin: search from pointer+1 upward with wrap.
  - Latch the winner index into grant_id and the pointer, latch the winner's req_op, load the wait counter with WAIT_CYCLES-1, go to ADDR.
  - With no request, stay in IDLE.
- ADDR: a_addr_n[grant_id]=0, all other bits 1.
  - The counter decrements each cycle.
  - When the counter reaches 0: ack[grant_id]=1 for this cycle only, then go to POST if the latched op is inc or dec, else to GAP.
- POST: a_addr_n all 1; inc[grant_id]=1 (op 01) or dec[grant_id]=1 (op 10) for exactly one cycle; go to GAP.
- GAP: all a_addr_n 1, inc/dec 0. This cycle is bus turnaround and the strobe falling edge; go to IDLE.
- inc and dec are never both high; no strobe is raised while any a_addr_n bit is low.
- Latency: grant request seen in IDLE cycle n → a_addr_n low from cycle n+1.
- Access length: 1 + WAIT_CYCLES + (1 if op) + 1 cycles, IDLE included.
- Requester handshake:
  - Keep req high until ack, then drop it by the next edge.
  - Because of POST/GAP, a dropped request is never re-granted.
  - A requester that keeps req high is re-queued round-robin.
- req dropped mid-access: ignored; the access, ack and post-op still complete.
- req_op changed after grant: ignored.
- grant_id holds its value in IDLE.
- Simultaneous requests: exactly one winner per IDLE decision. Losers wait; no loss, no starvation (each waits at most NREQ-1 accesses).

Optional Feature:
- Macro CAR_ARB_FIXED_PRI_EN.
- Defined: fixed priority, lowest index wins; the pointer is not used (it may still be updated), so requester 0 can starve others.
- Undefined (default): round-robin as above.

Test Plan:
- NREQ=4, WAIT_CYCLES=2; reset, then req=0001, op0=01 → a_addr_n=1110 for 2 cycles, ack=0001 in the 2nd, then inc[0] high 1 cycle, GAP, busy low; 5 cycles total.
- req=1111 held, all ops 00 → grants 0,1,2,3,0 in order, each 4 cycles; never two a_addr_n bits low.
- req=0100, op2=10, op changed to 01 during ADDR → dec[2] pulses once, inc stays 0.
- clear_n low in ADDR cycle 1 of a grant to requester 3 → a_addr_n=1111, ack=0, busy=0 immediately; after release with req=0001, requester 0 is granted first.
- req=0010 dropped after 1 ADDR cycle, op1=11 → access runs the full 2 cycles, ack[1] pulses, no inc/dec, straight to GAP.
- With CAR_ARB_FIXED_PRI_EN defined, req=0011 held → requester 0 granted on every access, requester 1 never.

Source files
------------

// File: rtl/car_addr_arbiter.sv
// Address-bus arbiter for the counter/address register bank: grants one register per access, then issues its post-inc/dec strobe.
// Optional build macro CAR_ARB_FIXED_PRI_EN selects fixed lowest-index priority instead of round-robin.
module car_addr_arbiter #(
  parameter int NREQ        = 4,
  parameter int WAIT_CYCLES = 1,
  parameter int GW          = $clog2(NREQ)
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] req_op,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   a_addr_n,
  output logic [NREQ-1:0]   inc,
  output logic [NREQ-1:0]   dec,
  output logic              busy,
  output logic [GW-1:0]     grant_id
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_POST = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  localparam logic [1:0] OP_INC = 2'b01;
  localparam logic [1:0] OP_DEC = 2'b10;

  localparam logic [GW-1:0] PTR_INIT = GW'(NREQ - 1);
  localparam logic [3:0]    CNT_LOAD = 4'(WAIT_CYCLES - 1);

  logic [1:0]      r_state;
  logic [3:0]      r_cnt;
  logic [GW-1:0]   r_ptr;
  logic [GW-1:0]   r_grant;
  logic [1:0]      r_op;
  logic [NREQ-1:0] r_ack;
  logic [NREQ-1:0] r_addr_n;
  logic [NREQ-1:0] r_inc;
  logic [NREQ-1:0] r_dec;
  logic            r_busy;

  logic [1:0]      w_next_state;
  logic [3:0]      w_next_cnt;
  logic [GW-1:0]   w_next_ptr;
  logic [GW-1:0]   w_next_grant;
  logic [1:0]      w_next_op;
  logic [GW-1:0]   w_winner;
  logic [GW-1:0]   w_idx;
  logic            w_found;
  logic [1:0]      w_win_op;
  logic [NREQ-1:0] w_next_onehot;
  logic            w_op_active;

  // Winner selection; only consulted while the FSM sits in IDLE.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_idx    = '0;
`ifdef CAR_ARB_FIXED_PRI_EN
    for (int i = 0; i < NREQ; i++) begin
      w_idx = GW'(i);
      if (!w_found && req[w_idx]) begin
        w_winner = w_idx;
        w_found  = 1'b1;
      end
    end
`else
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = GW'((int'(r_ptr) + k) % NREQ);
      if (!w_found && req[w_idx]) begin
        w_winner = w_idx;
        w_found  = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    w_win_op = 2'b00;
    for (int i = 0; i < NREQ; i++) begin
      if (GW'(i) == w_winner) begin
        w_win_op = req_op[2*i +: 2];
      end
    end
  end

  assign w_op_active = (r_op == OP_INC) || (r_op == OP_DEC);

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_ptr   = r_ptr;
    w_next_grant = r_grant;
    w_next_op    = r_op;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_next_state = S_ADDR;
          w_next_cnt   = CNT_LOAD;
          w_next_ptr   = w_winner;
          w_next_grant = w_winner;
          w_next_op    = w_win_op;
        end
      end
      S_ADDR: begin
        if (r_cnt == 4'd0) begin
          w_next_state = w_op_active ? S_POST : S_GAP;
        end else begin
          w_next_cnt = r_cnt - 4'd1;
        end
      end
      S_POST:  w_next_state = S_GAP;
      S_GAP:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_next_onehot = {{(NREQ-1){1'b0}}, 1'b1} << w_next_grant;

  // Outputs are decoded from the next state so that every port comes straight from a flop.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_ptr    <= PTR_INIT;
      r_grant  <= '0;
      r_op     <= 2'b00;
      r_ack    <= '0;
      r_addr_n <= '1;
      r_inc    <= '0;
      r_dec    <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_cnt    <= w_next_cnt;
      r_ptr    <= w_next_ptr;
      r_grant  <= w_next_grant;
      r_op     <= w_next_op;
      r_addr_n <= (w_next_state == S_ADDR) ? ~w_next_onehot : '1;
      r_ack    <= ((w_next_state == S_ADDR) && (w_next_cnt == 4'd0)) ? w_next_onehot : '0;
      r_inc    <= ((w_next_state == S_POST) && (w_next_op == OP_INC)) ? w_next_onehot : '0;
      r_dec    <= ((w_next_state == S_POST) && (w_next_op == OP_DEC)) ? w_next_onehot : '0;
      r_busy   <= (w_next_state != S_IDLE);
    end
  end

  assign ack      = r_ack;
  assign a_addr_n = r_addr_n;
  assign inc      = r_inc;
  assign dec      = r_dec;
  assign busy     = r_busy;
  assign grant_id = r_grant;

endmodule
